mret_return_ctrl: RTL and testbench

Sequences the exit side of machine-mode trap handling: when an `mret` reaches the MEM stage, it flushes the younger pipeline stages and redirects fetch to the saved `mepc`. It also commits the `mstatus` MIE/MPIE restore and holds off new interrupts until the redirect has been accepted. It sits in the CSR block beside the trap-entry `mepc` address selector and is the return-path counterpart of trap entry.

---
 rtl/mret_return_ctrl.sv | 118 +++++++++++
 tb/tb_mret_return_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mret_return_ctrl.sv
// mret_return_ctrl
// Exit-side sequencer for machine-mode traps. When an mret reaches MEM it
// flushes the younger pipeline stages, redirects fetch to the saved mepc,
// and then commits the mstatus MIE/MPIE restore. New interrupts stay masked
// while a sequence is in progress.
//
// Ports
//   clk                 core clock
//   reset_n             synchronous active-low reset
//   mret_mem            valid mret in MEM this cycle
//   trap_taken          trap entry taken this cycle (beats mret, aborts sequence)
//   mepc                current mepc CSR
//   mstatus_mpie        current mstatus.MPIE
//   fetch_ack           fetch unit accepted the redirect
//   pipe_flush          clear IF/ID, ID/EXE, EXE/MEM
//   pc_redirect_valid   redirect request to fetch
//   pc_redirect_target  redirect address (latched, word aligned)
//   mstatus_we          MIE/MPIE write strobe
//   mstatus_mie_next    value for MIE
//   mstatus_mpie_next   value for MPIE
//   mret_busy           sequence in progress
//   mret_done           one-cycle completion pulse
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for an mret in MEM that is not beaten by a trap
// FLUSH    | holding pipe_flush for FLUSH_CYCLES cycles (down-counter)
// REDIRECT | requesting fetch redirect until fetch_ack
// DONE     | one-cycle mstatus restore and completion pulse

module mret_return_ctrl #(
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mret_mem,
   input  logic        trap_taken,
   input  logic [31:0] mepc,
   input  logic        mstatus_mpie,
   input  logic        fetch_ack,
   output logic        pipe_flush,
   output logic        pc_redirect_valid,
   output logic [31:0] pc_redirect_target,
   output logic        mstatus_we,
   output logic        mstatus_mie_next,
   output logic        mstatus_mpie_next,
   output logic        mret_busy,
   output logic        mret_done
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLUSH    = 2'd1,
      REDIRECT = 2'd2,
      DONE     = 2'd3
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] target_q;
   logic        mpie_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         target_q <= 32'h0000_0000;
         mpie_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               // A simultaneous trap wins; the mret is dropped.
               if (mret_mem && !trap_taken) begin
                  // No compressed instructions, so the low two bits are forced to 0.
                  target_q <= mepc & 32'hFFFF_FFFC;
                  mpie_q   <= mstatus_mpie;
                  cnt_q    <= CNT_LOAD;
                  state_q  <= FLUSH;
               end
            end
            FLUSH: begin
               if (trap_taken) begin
                  state_q <= IDLE;
               end else if (cnt_q == 4'd0) begin
                  state_q <= REDIRECT;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            REDIRECT: begin
               // Trap entry takes over the PC; no restore is committed.
               if (trap_taken) begin
                  state_q <= IDLE;
               end else if (fetch_ack) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               // The restore always completes once the redirect was accepted.
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign pipe_flush         = (state_q == FLUSH);
   assign pc_redirect_valid  = (state_q == REDIRECT);
   assign pc_redirect_target = target_q;
   assign mstatus_we         = (state_q == DONE);
   assign mstatus_mie_next   = (state_q == DONE) & mpie_q;
   assign mstatus_mpie_next  = (state_q == DONE);
   assign mret_busy          = (state_q != IDLE);
   assign mret_done          = (state_q == DONE);

endmodule

// File: tb/tb_mret_return_ctrl.sv
module tb_mret_return_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        mret_mem;
   logic        trap_taken;
   logic [31:0] mepc;
   logic        mstatus_mpie;
   logic        fetch_ack;
   logic        pipe_flush;
   logic        pc_redirect_valid;
   logic [31:0] pc_redirect_target;
   logic        mstatus_we;
   logic        mstatus_mie_next;
   logic        mstatus_mpie_next;
   logic        mret_busy;
   logic        mret_done;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   mret_return_ctrl #(.FLUSH_CYCLES(2)) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .mret_mem           (mret_mem),
      .trap_taken         (trap_taken),
      .mepc               (mepc),
      .mstatus_mpie       (mstatus_mpie),
      .fetch_ack          (fetch_ack),
      .pipe_flush         (pipe_flush),
      .pc_redirect_valid  (pc_redirect_valid),
      .pc_redirect_target (pc_redirect_target),
      .mstatus_we         (mstatus_we),
      .mstatus_mie_next   (mstatus_mie_next),
      .mstatus_mpie_next  (mstatus_mpie_next),
      .mret_busy          (mret_busy),
      .mret_done          (mret_done)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Compare every output against a hand-computed vector.
   task automatic chk_out(input string tag, input logic fl, input logic rv,
                          input logic [31:0] tgt, input logic we, input logic mie,
                          input logic mpie, input logic busy, input logic done);
      chk({tag, ".flush"},  {31'd0, pipe_flush},        {31'd0, fl});
      chk({tag, ".rv"},     {31'd0, pc_redirect_valid}, {31'd0, rv});
      chk({tag, ".tgt"},    pc_redirect_target,         tgt);
      chk({tag, ".we"},     {31'd0, mstatus_we},        {31'd0, we});
      chk({tag, ".mie"},    {31'd0, mstatus_mie_next},  {31'd0, mie});
      chk({tag, ".mpie"},   {31'd0, mstatus_mpie_next}, {31'd0, mpie});
      chk({tag, ".busy"},   {31'd0, mret_busy},         {31'd0, busy});
      chk({tag, ".done"},   {31'd0, mret_done},         {31'd0, done});
   endtask

   initial begin
      reset_n      = 1'b0;
      mret_mem     = 1'b0;
      trap_taken   = 1'b0;
      mepc         = 32'h0;
      mstatus_mpie = 1'b0;
      fetch_ack    = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      chk_out("reset", 0, 0, 32'h0, 0, 0, 0, 0, 0);

      // Basic return.
      mepc = 32'h0000_1A44; mstatus_mpie = 1'b1; fetch_ack = 1'b1; mret_mem = 1'b1;
      step(); mret_mem = 1'b0;
      chk_out("basic.c1", 1, 0, 32'h0000_1A44, 0, 0, 0, 1, 0);
      step();
      chk_out("basic.c2", 1, 0, 32'h0000_1A44, 0, 0, 0, 1, 0);
      step();
      chk_out("basic.c3", 0, 1, 32'h0000_1A44, 0, 0, 0, 1, 0);
      step();
      chk_out("basic.c4", 0, 0, 32'h0000_1A44, 1, 1, 1, 1, 1);
      step();
      chk_out("basic.c5", 0, 0, 32'h0000_1A44, 0, 0, 0, 0, 0);

      // Misaligned mepc, changed after acceptance.
      mepc = 32'h0000_2003; mstatus_mpie = 1'b0; mret_mem = 1'b1;
      step(); mret_mem = 1'b0; mepc = 32'hFFFF_FFF0;
      chk_out("misal.c1", 1, 0, 32'h0000_2000, 0, 0, 0, 1, 0);
      step();
      chk("misal.c2.tgt", pc_redirect_target, 32'h0000_2000);
      step();
      chk_out("misal.c3", 0, 1, 32'h0000_2000, 0, 0, 0, 1, 0);
      step();
      chk_out("misal.c4", 0, 0, 32'h0000_2000, 1, 0, 1, 1, 1);
      step();
      chk("misal.c5.busy", {31'd0, mret_busy}, 32'd0);

      // Fetch backpressure: ack low for 5 REDIRECT cycles.
      fetch_ack = 1'b0; mepc = 32'h0000_0400; mstatus_mpie = 1'b1; mret_mem = 1'b1;
      step(); mret_mem = 1'b0;
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         chk_out($sformatf("bp.wait%0d", i), 0, 1, 32'h0000_0400, 0, 0, 0, 1, 0);
         step();
      end
      fetch_ack = 1'b1;
      chk_out("bp.ackcyc", 0, 1, 32'h0000_0400, 0, 0, 0, 1, 0);
      step(); fetch_ack = 1'b0;
      chk_out("bp.done", 0, 0, 32'h0000_0400, 1, 1, 1, 1, 1);
      step();
      chk_out("bp.idle", 0, 0, 32'h0000_0400, 0, 0, 0, 0, 0);

      // Trap priority over mret in the same cycle.
      mepc = 32'h0000_5550; mret_mem = 1'b1; trap_taken = 1'b1;
      step(); mret_mem = 1'b0; trap_taken = 1'b0;
      chk_out("prio.c1", 0, 0, 32'h0000_0400, 0, 0, 0, 0, 0);
      step();
      chk_out("prio.c2", 0, 0, 32'h0000_0400, 0, 0, 0, 0, 0);

      // Abort by trap during the second FLUSH cycle.
      mepc = 32'h0000_0800; fetch_ack = 1'b1; mret_mem = 1'b1;
      step(); mret_mem = 1'b0;
      chk("abort.c1.flush", {31'd0, pipe_flush}, 32'd1);
      step(); trap_taken = 1'b1;
      chk("abort.c2.flush", {31'd0, pipe_flush}, 32'd1);
      step(); trap_taken = 1'b0;
      chk_out("abort.c3", 0, 0, 32'h0000_0800, 0, 0, 0, 0, 0);
      step();
      chk_out("abort.c4", 0, 0, 32'h0000_0800, 0, 0, 0, 0, 0);

      // Reset in the middle of REDIRECT.
      mepc = 32'h0000_0088; mstatus_mpie = 1'b1; fetch_ack = 1'b0; mret_mem = 1'b1;
      step(); mret_mem = 1'b0;
      step();
      step();
      chk("rst.redirect", {31'd0, pc_redirect_valid}, 32'd1);
      reset_n = 1'b0;
      step(); reset_n = 1'b1;
      chk_out("rst.after", 0, 0, 32'h0, 0, 0, 0, 0, 0);
      step();
      chk_out("rst.after2", 0, 0, 32'h0, 0, 0, 0, 0, 0);

      // Fresh mret after reset with MPIE=0.
      mepc = 32'h0000_3000; mstatus_mpie = 1'b0; fetch_ack = 1'b1; mret_mem = 1'b1;
      step(); mret_mem = 1'b0;
      chk_out("fresh.c1", 1, 0, 32'h0000_3000, 0, 0, 0, 1, 0);
      step();
      step();
      chk_out("fresh.c3", 0, 1, 32'h0000_3000, 0, 0, 0, 1, 0);
      step();
      chk_out("fresh.c4", 0, 0, 32'h0000_3000, 1, 0, 1, 1, 1);
      step();
      chk_out("fresh.c5", 0, 0, 32'h0000_3000, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
